// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types and constants for the Dcache port arbiter and its store buffer.
package dcache_port_arbiter_pkg;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int PR_W     = 7;
  localparam int AR_W     = 5;
  // Lowest address bit that distinguishes two 64-bit words.
  localparam int WORD_LSB = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_BUSY = 2'd1,
    ST_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_LD   = 2'd1,
    SEL_ST   = 2'd2
  } arb_sel_e;

  // True when both addresses fall in the same aligned 64-bit word.
  function automatic logic same_word(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:WORD_LSB] == b[ADDR_W-1:WORD_LSB];
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// LSQ load port, retired-store port, buffer status and Dcache command bus.
interface dcache_port_arbiter_if #(parameter int SB_DEPTH = 4);
  import dcache_port_arbiter_pkg::*;

  logic                      lsq_rd_req;
  logic [ADDR_W-1:0]         lsq_rd_addr;
  logic [PR_W-1:0]           lsq_rd_pr_idx;
  logic [AR_W-1:0]           lsq_rd_ar_idx;
  logic                      lsq_rd_grant;

  logic                      st_retire_valid;
  logic [ADDR_W-1:0]         st_retire_addr;
  logic [DATA_W-1:0]         st_retire_value;

  logic                      sb_full;
  logic [$clog2(SB_DEPTH):0] sb_count;
  logic                      sb_overflow;

  logic                      mem_ready;
  logic                      mem_ack;
  logic                      Dcache_rd_mem;
  logic                      Dcache_wr_mem;
  logic [ADDR_W-1:0]         Dcache_addr;
  logic [DATA_W-1:0]         Dcache_st_value;
  logic [PR_W-1:0]           Dcache_pr_idx;
  logic [AR_W-1:0]           Dcache_ar_idx;

  // Arbiter side.
  modport master (
    input  lsq_rd_req, lsq_rd_addr, lsq_rd_pr_idx, lsq_rd_ar_idx,
    input  st_retire_valid, st_retire_addr, st_retire_value,
    input  mem_ready, mem_ack,
    output lsq_rd_grant, sb_full, sb_count, sb_overflow,
    output Dcache_rd_mem, Dcache_wr_mem, Dcache_addr, Dcache_st_value,
    output Dcache_pr_idx, Dcache_ar_idx
  );

  // LSQ / retire / Dcache side.
  modport slave (
    output lsq_rd_req, lsq_rd_addr, lsq_rd_pr_idx, lsq_rd_ar_idx,
    output st_retire_valid, st_retire_addr, st_retire_value,
    output mem_ready, mem_ack,
    input  lsq_rd_grant, sb_full, sb_count, sb_overflow,
    input  Dcache_rd_mem, Dcache_wr_mem, Dcache_addr, Dcache_st_value,
    input  Dcache_pr_idx, Dcache_ar_idx
  );

endinterface

// File: rtl/store_buffer_fifo.sv
// Retired-store FIFO: wrapping head/tail pointers, sticky overflow flag and a
// per-entry same-word match vector used for load/store conflict detection.
module store_buffer_fifo
  import dcache_port_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_value_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] cmp_addr_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_value_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [PTR_W:0]    count_o,
  output logic              overflow_o,
  output logic [DEPTH-1:0]  match_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              do_push, do_pop;
  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [DATA_W-1:0] value_mem [DEPTH];

  assign full_o       = (count_q == FULL_CNT);
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign head_addr_o  = addr_mem[head_q];
  assign head_value_o = value_mem[head_q];

  // A pop frees the slot this cycle, so a push while full is legal with a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Entry i is live when its distance from head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [PTR_W-1:0] rel;
    assign rel        = PTR_W'(i) - head_q;
    assign valid[i]   = {1'b0, rel} < count_q;
    assign match_o[i] = valid[i] && same_word(addr_mem[i], cmp_addr_i);
  end

  // Next pointer/count/overflow values.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_i && full_o && !do_pop);
    if (do_push) tail_d = tail_q + 1'b1;
    if (do_pop)  head_d = head_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values; comb logic uses =.
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately not reset; the valid window (head/count) masks stale data.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[tail_q]  <= push_addr_i;
      value_mem[tail_q] <= push_value_i;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Single-port Dcache arbiter between LSQ loads and buffered retired stores.
// One command outstanding at a time; stores win when the buffer is full or
// loads have bypassed them STARVE_LIM times in a row.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int SB_DEPTH   = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dcache_port_arbiter_if.master bus
);

  localparam int               CNT_W      = $clog2(SB_DEPTH) + 1;
  localparam int               STV_W      = $clog2(STARVE_LIM + 1);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIM);

  arb_state_e        state_q, state_d;
  arb_sel_e          sel;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic [PR_W-1:0]   pr_q, pr_d;
  logic [AR_W-1:0]   ar_q, ar_d;
  logic              ack_ok, sb_pop, sb_empty, sb_full, conflict;
  logic [CNT_W-1:0]  sb_count;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_value;
  logic [SB_DEPTH-1:0] match;

  store_buffer_fifo #(.DEPTH(SB_DEPTH)) u_sbuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (bus.st_retire_valid),
    .push_addr_i  (bus.st_retire_addr),
    .push_value_i (bus.st_retire_value),
    .pop_i        (sb_pop),
    .cmp_addr_i   (bus.lsq_rd_addr),
    .head_addr_o  (head_addr),
    .head_value_o (head_value),
    .full_o       (sb_full),
    .empty_o      (sb_empty),
    .count_o      (sb_count),
    .overflow_o   (bus.sb_overflow),
    .match_o      (match)
  );

  assign conflict        = |match;
  assign bus.lsq_rd_grant = (sel == SEL_LD);
  assign bus.sb_full     = sb_full;
  assign bus.sb_count    = sb_count;
  assign bus.Dcache_rd_mem   = rd_q;
  assign bus.Dcache_wr_mem   = wr_q;
  assign bus.Dcache_addr     = addr_q;
  assign bus.Dcache_st_value = value_q;
  assign bus.Dcache_pr_idx   = pr_q;
  assign bus.Dcache_ar_idx   = ar_q;

  // Selection, FSM next state, starvation counter and command fields.
  always_comb begin
    sel      = SEL_NONE;
    state_d  = state_q;
    starve_d = starve_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    value_d  = value_q;
    pr_d     = pr_q;
    ar_d     = ar_q;

    if (state_q == IDLE && bus.mem_ready) begin
      if (!sb_empty && (sb_full || starve_q == STARVE_MAX)) sel = SEL_ST;
      else if (bus.lsq_rd_req && !conflict)                sel = SEL_LD;
      else if (!sb_empty)                                  sel = SEL_ST;
    end

    // The command pulse cycle itself never counts as an acknowledge.
    ack_ok = bus.mem_ack && (state_q != IDLE) && !(rd_q || wr_q);
    sb_pop = ack_ok && (state_q == ST_BUSY);

    unique case (state_q)
      IDLE: begin
        if (sel == SEL_LD)      state_d = LD_BUSY;
        else if (sel == SEL_ST) state_d = ST_BUSY;
      end
      LD_BUSY, ST_BUSY: if (ack_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (sb_empty || sel == SEL_ST)             starve_d = '0;
    else if (sel == SEL_LD && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;

    if (sel == SEL_LD) begin
      rd_d   = 1'b1;
      addr_d = bus.lsq_rd_addr;
      pr_d   = bus.lsq_rd_pr_idx;
      ar_d   = bus.lsq_rd_ar_idx;
    end else if (sel == SEL_ST) begin
      wr_d    = 1'b1;
      addr_d  = head_addr;
      value_d = head_value;
      pr_d    = '0;
      ar_d    = '0;
    end
  end

  // FSM, counter and registered Dcache command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      value_q  <= '0;
      pr_q     <= '0;
      ar_q     <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      value_q  <= value_d;
      pr_q     <= pr_d;
      ar_q     <= ar_d;
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench: a transaction-level reference model predicts grants,
// buffer status and Dcache commands; a negedge monitor checks commands.
module tb_dcache_port_arbiter;

  localparam int DEPTH = 4;
  localparam int LIM   = 4;

  typedef struct {
    bit          is_st;
    logic [63:0] addr;
    logic [63:0] value;
    logic [6:0]  pr;
    logic [4:0]  ar;
    int          cyc;
  } cmd_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] value;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  cmd_t        exp_q[$];
  st_t         sb_m[$];
  bit          m_out, m_out_st, m_ovf;
  int          m_cmd_cyc, m_starve;
  logic [63:0] m_last_value;
  bit          obs_log[$];   // 1 = store command observed, 0 = load

  // Stimulus for the next cycle.
  bit          in_req, in_sv, in_rdy, in_ack;
  logic [63:0] in_la, in_sa, in_sd;
  logic [6:0]  in_pr;
  logic [4:0]  in_ar;
  bit          last_grant;

  dcache_port_arbiter_if #(.SB_DEPTH(DEPTH)) bus ();

  dcache_port_arbiter #(.SB_DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    in_req = 0; in_sv = 0; in_rdy = 0; in_ack = 0;
    in_la = '0; in_sa = '0; in_sd = '0; in_pr = '0; in_ar = '0;
  endtask

  // One clock: drive inputs, check combinational/status outputs, advance model.
  task automatic step();
    bit full, ne, conflict, ack_eff, pop;
    int sel;
    @(posedge clk);
    #2;
    bus.lsq_rd_req      = in_req;
    bus.lsq_rd_addr     = in_la;
    bus.lsq_rd_pr_idx   = in_pr;
    bus.lsq_rd_ar_idx   = in_ar;
    bus.st_retire_valid = in_sv;
    bus.st_retire_addr  = in_sa;
    bus.st_retire_value = in_sd;
    bus.mem_ready       = in_rdy;
    bus.mem_ack         = in_ack;
    #1;
    full = (sb_m.size() == DEPTH);
    ne   = (sb_m.size() != 0);
    conflict = 0;
    foreach (sb_m[i]) if ((sb_m[i].addr >> 3) == (in_la >> 3)) conflict = 1;
    sel = 0;
    if (!m_out && in_rdy) begin
      if (ne && (full || m_starve == LIM)) sel = 2;
      else if (in_req && !conflict)        sel = 1;
      else if (ne)                         sel = 2;
    end
    check("sb_count", 64'(bus.sb_count), 64'(sb_m.size()));
    check("sb_full", 64'(bus.sb_full), 64'(full));
    check("sb_overflow", 64'(bus.sb_overflow), 64'(m_ovf));
    check("lsq_rd_grant", 64'(bus.lsq_rd_grant), 64'(sel == 1));
    last_grant = (sel == 1);

    ack_eff = m_out && in_ack && (cyc > m_cmd_cyc);
    pop     = ack_eff && m_out_st;
    if (!ne || sel == 2)             m_starve = 0;
    else if (sel == 1 && m_starve < LIM) m_starve++;
    if (sel == 1)
      exp_q.push_back('{is_st: 1'b0, addr: in_la, value: m_last_value, pr: in_pr, ar: in_ar, cyc: cyc + 1});
    if (sel == 2) begin
      exp_q.push_back('{is_st: 1'b1, addr: sb_m[0].addr, value: sb_m[0].value, pr: 7'd0, ar: 5'd0, cyc: cyc + 1});
      m_last_value = sb_m[0].value;
    end
    if (sel != 0) begin
      m_out = 1; m_out_st = (sel == 2); m_cmd_cyc = cyc + 1;
    end
    if (ack_eff) m_out = 0;
    if (pop) void'(sb_m.pop_front());
    if (in_sv) begin
      if (sb_m.size() < DEPTH) sb_m.push_back('{addr: in_sa, value: in_sd});
      else m_ovf = 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clear_inputs();
    bus.lsq_rd_req = 0; bus.st_retire_valid = 0; bus.mem_ready = 0; bus.mem_ack = 0;
    #1;
    check("rst_rd_mem", 64'(bus.Dcache_rd_mem), 0);
    check("rst_wr_mem", 64'(bus.Dcache_wr_mem), 0);
    check("rst_addr", bus.Dcache_addr, 0);
    check("rst_value", bus.Dcache_st_value, 0);
    check("rst_pr_ar", 64'({bus.Dcache_pr_idx, bus.Dcache_ar_idx}), 0);
    check("rst_count", 64'(bus.sb_count), 0);
    check("rst_full_ovf", 64'({bus.sb_full, bus.sb_overflow}), 0);
    exp_q.delete(); sb_m.delete();
    m_out = 0; m_out_st = 0; m_ovf = 0; m_starve = 0; m_cmd_cyc = 0; m_last_value = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    clear_inputs();
    in_rdy = 1; in_ack = 1;
    while ((sb_m.size() != 0 || m_out) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) check("drain_timeout", 64'(n), 64'(limit - 1));
    step();
    step();
  endtask

  // Command monitor: pop the expected command whenever the DUT pulses.
  cmd_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.Dcache_rd_mem || bus.Dcache_wr_mem) begin
        obs_log.push_back(bus.Dcache_wr_mem);
        check("rd_wr_exclusive", 64'(bus.Dcache_rd_mem & bus.Dcache_wr_mem), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("cmd_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("cmd_wr_mem", 64'(bus.Dcache_wr_mem), 64'(mon_e.is_st));
          check("cmd_addr", bus.Dcache_addr, mon_e.addr);
          check("cmd_st_value", bus.Dcache_st_value, mon_e.value);
          check("cmd_pr_idx", 64'(bus.Dcache_pr_idx), 64'(mon_e.pr));
          check("cmd_ar_idx", 64'(bus.Dcache_ar_idx), 64'(mon_e.ar));
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        check("missing_cmd", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, n, loads;
    bit pend;
    clear_inputs();
    do_reset();

    // Idle load: grant same cycle, pulse next cycle, ack two cycles after pulse.
    in_req = 1; in_la = 64'h100; in_pr = 7'd9; in_ar = 5'd3; in_rdy = 1;
    step();
    check("idle_load_grant", 64'(last_grant), 1);
    in_req = 0;
    step();
    step();
    in_ack = 1; step(); in_ack = 0;
    step(); step();

    // Store drain.
    clear_inputs();
    in_sv = 1; in_sa = 64'h200; in_sd = 64'hDEAD;
    step();
    in_sv = 0; in_rdy = 1;
    step(); step();
    in_ack = 1; step(); in_ack = 0;
    step();
    check("store_drain_count", 64'(bus.sb_count), 0);

    // Conflict: load to same word as buffered store waits for the store.
    clear_inputs();
    in_sv = 1; in_sa = 64'h300; in_sd = 64'h1234;
    step();
    base = obs_log.size();
    in_sv = 0; in_req = 1; in_la = 64'h304; in_pr = 7'd5; in_ar = 5'd7; in_rdy = 1; in_ack = 1;
    n = 0;
    do begin step(); n++; end while (!last_grant && n < 20);
    check("conflict_grant_timeout", 64'(last_grant), 1);
    in_req = 0;
    step(); step();
    check("conflict_cmds", 64'(obs_log.size() - base), 2);
    if (obs_log.size() >= base + 2) begin
      check("conflict_first_is_store", 64'(obs_log[base]), 1);
      check("conflict_second_is_load", 64'(obs_log[base + 1]), 0);
    end
    drain(20);

    // Starvation: four loads bypass one buffered store, then the store goes.
    clear_inputs();
    in_sv = 1; in_sa = 64'h400; in_sd = 64'hBEEF;
    step();
    in_sv = 0; in_rdy = 1; in_ack = 1; in_req = 1;
    base = obs_log.size();
    n = 0;
    while (obs_log.size() < base + 5 && n < 60) begin
      in_la = 64'h1000 + 64'(n) * 8; in_pr = 7'(n); in_ar = 5'(n);
      step();
      n++;
    end
    check("starve_timeout", 64'(obs_log.size() >= base + 5), 1);
    loads = 0;
    for (int i = base; i < obs_log.size() && !obs_log[i]; i++) loads++;
    check("starve_loads_before_store", 64'(loads), 4);
    drain(40);

    // Full and overflow, then push with simultaneous pop-ack.
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      in_sv = 1; in_sa = 64'h500 + 64'(i) * 8; in_sd = 64'hA0 + 64'(i);
      step();
    end
    in_sv = 0;
    step();
    check("overflow_set", 64'(bus.sb_overflow), 1);
    check("overflow_count", 64'(bus.sb_count), 4);
    in_rdy = 1; step(); step();
    in_ack = 1; in_sv = 1; in_sa = 64'h580; in_sd = 64'hFF;
    step();
    in_ack = 0; in_sv = 0; in_rdy = 0;
    step();
    check("push_pop_full_count", 64'(bus.sb_count), 4);
    check("push_pop_full_ovf", 64'(bus.sb_overflow), 1);
    drain(40);

    // Reset during LD_BUSY; later ack must be ignored.
    clear_inputs();
    in_req = 1; in_la = 64'h700; in_pr = 7'd1; in_ar = 5'd1; in_rdy = 1;
    step();
    in_req = 0;
    step();
    do_reset();
    clear_inputs();
    in_ack = 1; in_sv = 1; in_sa = 64'h800; in_sd = 64'h55;
    step();
    in_sv = 0;
    step(); step(); step();
    check("post_reset_no_pop", 64'(bus.sb_count), 1);
    drain(20);

    // Randomized traffic against the model.
    clear_inputs();
    pend = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) begin
        do_reset();
        pend = 0;
        clear_inputs();
      end
      if (!pend && ($urandom % 2 == 0)) begin
        pend = 1; in_req = 1;
        in_la = 64'h2000 + 64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 7));
        in_pr = 7'($urandom); in_ar = 5'($urandom);
      end
      in_sv  = ($urandom % 4 == 0);
      in_sa  = 64'h2000 + 64'($urandom_range(0, 7)) * 8;
      in_sd  = {32'($urandom), 32'($urandom)};
      in_rdy = ($urandom % 5 != 0);
      in_ack = ($urandom % 2 == 0);
      step();
      if (last_grant) begin pend = 0; in_req = 0; end
    end
    drain(100);
    check("exp_queue_drained", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
